// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters, sync pulses,
// display enable and line/frame markers, all registered and mutually aligned.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 1024,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 136,
    parameter int H_BP       = 160,
    parameter int V_ACTIVE   = 768,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 29,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CW         = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic          restart,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          h_sync,
    output logic          v_sync,
    output logic          EA,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_zero
        $error("vga_timing_gen: every active/porch/sync value must be non-zero");
    end
    if (H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_bad_width
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end

    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          hs_act_next;
    logic          vs_act_next;

    // Outputs are decoded from the position the counters are about to take,
    // so every registered output lines up with the registered counters.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a value
        // unassigned, which would otherwise infer a latch.
        h_next = h_count;
        v_next = v_count;
        if (restart) begin
            h_next = '0;
            v_next = '0;
        end else if (pix_en) begin
            if (h_count == H_LAST) begin
                h_next = '0;
                v_next = (v_count == V_LAST) ? '0 : v_count + 1'b1;
            end else begin
                h_next = h_count + 1'b1;
            end
        end
        hs_act_next = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
        vs_act_next = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_count     <= '0;
            v_count     <= '0;
            h_sync      <= ~H_SYNC_POL;
            v_sync      <= ~V_SYNC_POL;
            EA          <= 1'b1;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            h_count     <= h_next;
            v_count     <= v_next;
            h_sync      <= hs_act_next ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync      <= vs_act_next ? V_SYNC_POL : ~V_SYNC_POL;
            EA          <= (h_next < H_ACT) && (v_next < V_ACT);
            line_start  <= (h_next == '0);
            frame_start <= (h_next == '0) && (v_next == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, small, short-frame) checked
// cycle by cycle against a behavioural raster model through a scoreboard queue.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        ea;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct {
        int h_act, h_fp, h_sync, h_bp;
        int v_act, v_fp, v_sync, v_bp;
        bit h_pol, v_pol;
    } cfg_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] pix_en = '0;
    logic [2:0] restart = '0;

    logic [10:0] a_h, a_v, b_h, b_v, c_h, c_v;
    logic a_hs, a_vs, a_ea, a_ls, a_fs;
    logic b_hs, b_vs, b_ea, b_ls, b_fs;
    logic c_hs, c_vs, c_ea, c_ls, c_fs;

    int checks = 0;
    int failures = 0;

    cfg_t cfg[3];
    int   mh[3];
    int   mv[3];
    obs_t sb[$];

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst), .pix_en(pix_en[0]), .restart(restart[0]),
        .h_count(a_h), .v_count(a_v), .h_sync(a_hs), .v_sync(a_vs),
        .EA(a_ea), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CW(11)
    ) dut_b (
        .clk(clk), .rst(rst), .pix_en(pix_en[1]), .restart(restart[1]),
        .h_count(b_h), .v_count(b_v), .h_sync(b_hs), .v_sync(b_vs),
        .EA(b_ea), .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing_gen #(
        .V_ACTIVE(4), .V_FP(3), .V_SYNC(6), .V_BP(2)
    ) dut_c (
        .clk(clk), .rst(rst), .pix_en(pix_en[2]), .restart(restart[2]),
        .h_count(c_h), .v_count(c_v), .h_sync(c_hs), .v_sync(c_vs),
        .EA(c_ea), .line_start(c_ls), .frame_start(c_fs)
    );

    function automatic obs_t get_obs(input int d);
        case (d)
            0:       return {a_h, a_v, a_hs, a_vs, a_ea, a_ls, a_fs};
            1:       return {b_h, b_v, b_hs, b_vs, b_ea, b_ls, b_fs};
            default: return {c_h, c_v, c_hs, c_vs, c_ea, c_ls, c_fs};
        endcase
    endfunction

    function automatic obs_t model_obs(input int d);
        obs_t o;
        bit   hs_act, vs_act;
        int   hs0, vs0;
        hs0    = cfg[d].h_act + cfg[d].h_fp;
        vs0    = cfg[d].v_act + cfg[d].v_fp;
        hs_act = (mh[d] >= hs0) && (mh[d] < hs0 + cfg[d].h_sync);
        vs_act = (mv[d] >= vs0) && (mv[d] < vs0 + cfg[d].v_sync);
        o.h  = 11'(mh[d]);
        o.v  = 11'(mv[d]);
        o.hs = cfg[d].h_pol ? hs_act : !hs_act;
        o.vs = cfg[d].v_pol ? vs_act : !vs_act;
        o.ea = (mh[d] < cfg[d].h_act) && (mv[d] < cfg[d].v_act);
        o.ls = (mh[d] == 0);
        o.fs = (mh[d] == 0) && (mv[d] == 0);
        return o;
    endfunction

    task automatic model_advance(input int d);
        int htot, vtot;
        htot = cfg[d].h_act + cfg[d].h_fp + cfg[d].h_sync + cfg[d].h_bp;
        vtot = cfg[d].v_act + cfg[d].v_fp + cfg[d].v_sync + cfg[d].v_bp;
        if (mh[d] == htot - 1) begin
            mh[d] = 0;
            mv[d] = (mv[d] == vtot - 1) ? 0 : mv[d] + 1;
        end else begin
            mh[d] = mh[d] + 1;
        end
    endtask

    // One clock for instance d; the other instances see pix_en=0 and hold.
    task automatic step(input int d, input bit en, input bit rs);
        obs_t got, want;
        pix_en     = '0;
        restart    = '0;
        pix_en[d]  = en;
        restart[d] = rs;
        if (rs) begin
            mh[d] = 0;
            mv[d] = 0;
        end else if (en) begin
            model_advance(d);
        end
        sb.push_back(model_obs(d));
        @(posedge clk);
        #1;
        pix_en  = '0;
        restart = '0;
        got = get_obs(d);
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty dut%0d", d);
        end else begin
            want = sb.pop_front();
            if (got !== want) begin
                failures++;
                if (failures <= 30)
                    $display("FAIL step dut%0d: got h=%0d v=%0d hs=%b vs=%b ea=%b ls=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b ea=%b ls=%b fs=%b",
                             d, got.h, got.v, got.hs, got.vs, got.ea, got.ls, got.fs,
                             want.h, want.v, want.hs, want.vs, want.ea, want.ls, want.fs);
            end
        end
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic expect_obs(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic reset_models();
        for (int d = 0; d < 3; d++) begin
            mh[d] = 0;
            mv[d] = 0;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        pix_en = '1;
        #3;
        expect_obs("reset_a", get_obs(0), {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        expect_obs("reset_b", get_obs(1), {11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
        @(posedge clk);
        #2;
        expect_obs("reset_hold_a", get_obs(0), {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        pix_en = '0;
        rst    = 1'b0;
        reset_models();
    endtask

    task automatic test_line();
        obs_t o;
        int hs_low = 0, hs_first = -1, hs_last = -1, ea_low = 0, ea_first = -1;
        for (int i = 0; i < 1344; i++) begin
            o = get_obs(0);
            if (o.v == 0 && o.hs == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(o.h);
                hs_last = int'(o.h);
            end
            if (o.v == 0 && o.ea == 1'b0) begin
                ea_low++;
                if (ea_first < 0) ea_first = int'(o.h);
            end
            step(0, 1'b1, 1'b0);
        end
        expect_int("line_hs_low_count", hs_low, 136);
        expect_int("line_hs_first", hs_first, 1048);
        expect_int("line_hs_last", hs_last, 1183);
        expect_int("line_ea_low_count", ea_low, 320);
        expect_int("line_ea_first", ea_first, 1024);
        o = get_obs(0);
        expect_int("line_wrap_h", int'(o.h), 0);
        expect_int("line_wrap_v", int'(o.v), 1);
        expect_int("line_wrap_ls", int'(o.ls), 1);
        expect_int("line_wrap_fs", int'(o.fs), 0);
    endtask

    task automatic test_restart();
        obs_t o;
        for (int i = 0; i < 500; i++) step(0, 1'b1, 1'b0);
        o = get_obs(0);
        expect_int("restart_pre_h", int'(o.h), 500);
        step(0, 1'b0, 1'b1);
        expect_obs("restart_idle", get_obs(0), {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        for (int i = 0; i < 17; i++) step(0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1);
        expect_obs("restart_priority", get_obs(0), {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
    endtask

    task automatic test_frame();
        obs_t o;
        int period = -1, prev_v = -1, vs_lines = 0, vs_first = -1, vs_last = -1;
        for (int n = 1; n <= 20200; n++) begin
            o = get_obs(2);
            prev_v = int'(o.v);
            if (o.h == 0 && o.vs == 1'b0) begin
                vs_lines++;
                if (vs_first < 0) vs_first = int'(o.v);
                vs_last = int'(o.v);
            end
            step(2, 1'b1, 1'b0);
            if (get_obs(2).fs == 1'b1) begin
                period = n;
                break;
            end
        end
        expect_int("frame_period", period, 20160);
        expect_int("frame_last_v", prev_v, 14);
        expect_int("frame_vs_lines", vs_lines, 6);
        expect_int("frame_vs_first", vs_first, 7);
        expect_int("frame_vs_last", vs_last, 12);
    endtask

    task automatic test_small();
        obs_t o;
        int period = -1, hs_hi = 0, hs_first = -1, vs_lines = 0, vs_first = -1;
        for (int n = 1; n <= 300; n++) begin
            o = get_obs(1);
            if (o.v == 0 && o.hs == 1'b1) begin
                hs_hi++;
                if (hs_first < 0) hs_first = int'(o.h);
            end
            if (o.h == 0 && o.vs == 1'b1) begin
                vs_lines++;
                if (vs_first < 0) vs_first = int'(o.v);
            end
            step(1, 1'b1, 1'b0);
            if (get_obs(1).fs == 1'b1) begin
                period = n;
                break;
            end
        end
        expect_int("small_period", period, 128);
        expect_int("small_hs_count", hs_hi, 3);
        expect_int("small_hs_first", hs_first, 10);
        expect_int("small_vs_lines", vs_lines, 2);
        expect_int("small_vs_first", vs_first, 5);
    endtask

    task automatic test_pix_en();
        int enabled = 0, period = -1;
        bit en;
        for (int n = 0; n < 1000; n++) begin
            en = ($urandom_range(0, 2) == 0);
            if (en) enabled++;
            step(1, en, 1'b0);
            if (en && get_obs(1).fs == 1'b1) begin
                period = enabled;
                break;
            end
        end
        expect_int("pix_en_period", period, 128);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 37; i++) step(0, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        expect_obs("async_reset_a", get_obs(0), {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        #1;
        rst = 1'b0;
        reset_models();
        step(0, 1'b1, 1'b0);
    endtask

    initial begin
        cfg[0] = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0};
        cfg[1] = '{8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1};
        cfg[2] = '{1024, 24, 136, 160, 4, 3, 6, 2, 1'b0, 1'b0};
        reset_models();
        #2;
        test_reset();
        test_line();
        test_restart();
        test_frame();
        test_small();
        test_pix_en();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
